data_bus_arbiter: RTL and testbench

- Shares the single 8-bit data-memory bus between NUM_MASTERS requesters: CPU core, debug module, DMA/peripheral masters.
- Each master drives a bus_req and receives a bus_grant. This matches the CPU's existing bus_req/bus_grant handshake, so the CPU plugs in unchanged as master 0.
- Arbitration is registered and round-robin.
- The granted master's address, write data and strobes are multiplexed onto the memory port.
- Read data is broadcast to all masters.

---
 rtl/data_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_bus_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one 8-bit data-memory bus between NUM_MASTERS requesters.
// Optional ARB_TIMEOUT_EN: forced revoke after MAX_HOLD grant cycles when others are waiting.
module data_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MASTERS-1:0]   bus_req,
  output logic [NUM_MASTERS-1:0]   bus_grant,
  input  logic [8*NUM_MASTERS-1:0] m_addr,
  input  logic [8*NUM_MASTERS-1:0] m_wr_data,
  input  logic [NUM_MASTERS-1:0]   m_wr,
  input  logic [NUM_MASTERS-1:0]   m_rd,
  output logic [7:0]               mem_addr,
  output logic [7:0]               mem_wr_data,
  output logic                     mem_wr,
  output logic                     mem_rd,
  output logic                     bus_busy,
  output logic [2:0]               owner,
  output logic                     timeout_err
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_HOLD < 2) begin : g_bad_cfg
    $error("data_bus_arbiter: NUM_MASTERS must be 2..8 and MAX_HOLD >= 2");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                         state, state_nxt;
  logic [2:0]                     owner_nxt, rr_ptr, rr_ptr_nxt, pick_start;
  logic [NUM_MASTERS-1:0]         grant_nxt, own_mask, others, pick_req;
  logic                           new_grant, revoke, holding;
  logic [NUM_MASTERS-1:0][7:0]    addr_v, wdat_v;

  function automatic logic [2:0] inc_wrap(input logic [2:0] x);
    return (int'(x) + 1 >= NUM_MASTERS) ? 3'd0 : x + 3'd1;
  endfunction

  // First requester at or after start, wrapping: smallest circular distance wins.
  function automatic logic [2:0] rr_pick(input logic [NUM_MASTERS-1:0] req, input logic [2:0] start);
    int         best, d;
    logic [2:0] pick;
    best = NUM_MASTERS;
    pick = start;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      d = i - int'(start);
      if (d < 0) d += NUM_MASTERS;
      if (req[i] && d < best) begin
        best = d;
        pick = 3'(i);
      end
    end
    return pick;
  endfunction

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    assign addr_v[i]   = m_addr[8*i +: 8];
    assign wdat_v[i]   = m_wr_data[8*i +: 8];
    assign own_mask[i] = (owner == 3'(i));
  end

  assign others   = bus_req & ~own_mask;
  assign holding  = |(bus_req & own_mask);
  assign bus_busy = (state == BUSY);

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_cnt;
  logic          tmo_q;
  assign revoke      = holding && (hold_cnt == HW'(MAX_HOLD-1)) && (|others);
  assign timeout_err = tmo_q;
`else
  assign revoke      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      bus_grant <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      bus_grant <= grant_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= revoke;
      if (new_grant)                                        hold_cnt <= '0;
      else if (bus_busy && hold_cnt != HW'(MAX_HOLD-1))     hold_cnt <= hold_cnt + HW'(1);
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    new_grant  = 1'b0;
    pick_req   = bus_req;
    pick_start = rr_ptr;
    case (state)
      IDLE: if (|bus_req) new_grant = 1'b1;
      BUSY: begin
        if (!holding || revoke) begin
          if (|others) begin
            new_grant  = 1'b1;
            pick_req   = others;
            pick_start = inc_wrap(owner);
          end else begin
            state_nxt = IDLE;
            owner_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (new_grant) begin
      state_nxt  = BUSY;
      owner_nxt  = rr_pick(pick_req, pick_start);
      rr_ptr_nxt = inc_wrap(owner_nxt);
    end
    grant_nxt = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      grant_nxt[i] = (state_nxt == BUSY) && (owner_nxt == 3'(i));
  end

  // Datapath mux from registered owner; idle presents master 0 with strobes off
  always_comb begin
    mem_addr    = addr_v[0];
    mem_wr_data = wdat_v[0];
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == 3'(i)) begin
        mem_addr    = addr_v[i];
        mem_wr_data = wdat_v[i];
        mem_wr      = bus_busy & m_wr[i];
        mem_rd      = bus_busy & m_rd[i];
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: reset, round-robin order, handover, idle, async reset, hold limit.
module tb_data_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  bus_req = '0, bus_grant, m_wr = '0, m_rd = '0;
  logic [31:0] m_addr = 32'h7733_2240, m_wr_data = 32'hD4C3_B2A1;
  logic [7:0]  mem_addr, mem_wr_data;
  logic        mem_wr, mem_rd, bus_busy, timeout_err;
  logic [2:0]  owner;
  int          checks = 0, errors = 0;

  data_bus_arbiter #(.NUM_MASTERS(4), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_grant(bus_grant),
    .m_addr(m_addr), .m_wr_data(m_wr_data), .m_wr(m_wr), .m_rd(m_rd),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .bus_busy(bus_busy), .owner(owner), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) chk("onehot", 32'($onehot0(bus_grant)), 32'd1);

  initial begin
    logic [3:0] prev;
    step(); step();
    chk("rst_grant", 32'(bus_grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(bus_busy), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);

    // First grant
    rst = 1'b1; bus_req = 4'b0001; m_wr = 4'b0001;
    step();
    chk("g0_grant", 32'(bus_grant), 32'h1);
    chk("g0_owner", 32'(owner), 32'h0);
    chk("g0_busy", 32'(bus_busy), 32'h1);
    chk("g0_wr", 32'(mem_wr), 32'h1);
    chk("g0_rd", 32'(mem_rd), 32'h0);
    chk("g0_addr", 32'(mem_addr), 32'h40);
    chk("g0_wdat", 32'(mem_wr_data), 32'hA1);

    // Round robin 0 -> 1 -> 2 -> 3 -> 0, each owner drops for one cycle
    bus_req = 4'b1111;
    step();
    chk("rr_hold0", 32'(bus_grant), 32'h1);
    prev = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      bus_req = 4'b1111 & ~prev;
      step();
      chk("rr_hand", 32'(bus_grant), 32'(4'b0001 << (k % 4)));
      chk("rr_busy", 32'(bus_busy), 32'h1);
      bus_req = 4'b1111;
      step();
      chk("rr_keep", 32'(bus_grant), 32'(4'b0001 << (k % 4)));
      prev = bus_grant;
    end

    // Owner 2 drops with 1 and 3 pending -> 3
    bus_req = 4'b0100;
    step();
    chk("m2_grant", 32'(bus_grant), 32'h4);
    bus_req = 4'b1110;
    step();
    chk("m2_hold", 32'(bus_grant), 32'h4);
    bus_req = 4'b1010;
    step();
    chk("m3_grant", 32'(bus_grant), 32'h8);
    chk("m3_owner", 32'(owner), 32'h3);
    m_wr = 4'b0010; #1;
    chk("m3_wr_ign", 32'(mem_wr), 32'h0);
    m_wr = 4'b1010; m_rd = 4'b0001; #1;
    chk("m3_wr", 32'(mem_wr), 32'h1);
    chk("m3_rd_ign", 32'(mem_rd), 32'h0);
    chk("m3_addr", 32'(mem_addr), 32'h77);
    chk("m3_wdat", 32'(mem_wr_data), 32'hD4);

    // Owner drops, nothing pending -> idle
    bus_req = 4'b0000; m_wr = 4'b1111; m_rd = 4'b1111;
    step();
    chk("idle_grant", 32'(bus_grant), 32'h0);
    chk("idle_busy", 32'(bus_busy), 32'h0);
    chk("idle_wr", 32'(mem_wr), 32'h0);
    chk("idle_rd", 32'(mem_rd), 32'h0);
    chk("idle_owner", 32'(owner), 32'h0);
    chk("idle_addr", 32'(mem_addr), 32'h40);

    // rr_ptr=0 after owner 3, so lone master 1 wins; reset mid-write
    bus_req = 4'b0010; m_rd = 4'b0000;
    step();
    chk("m1_grant", 32'(bus_grant), 32'h2);
    chk("m1_wr", 32'(mem_wr), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("arst_grant", 32'(bus_grant), 32'h0);
    chk("arst_wr", 32'(mem_wr), 32'h0);
    chk("arst_busy", 32'(bus_busy), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1; bus_req = 4'b0110;
    step();
    chk("post_rst", 32'(bus_grant), 32'h2);

    // Hold limit: master 0 owns, master 1 joins at grant cycle 3
    bus_req = 4'b0000;
    step();
    chk("idle2", 32'(bus_grant), 32'h0);
    bus_req = 4'b0001;
    step();
    chk("hold_c1", 32'(bus_grant), 32'h1);
    for (int c = 2; c <= 16; c++) begin
      step();
      if (c == 3) bus_req = 4'b0011;
      chk("hold_cyc", 32'(bus_grant), 32'h1);
      chk("hold_tmo", 32'(timeout_err), 32'h0);
    end
    step();
`ifdef ARB_TIMEOUT_EN
    chk("tmo_grant", 32'(bus_grant), 32'h2);
    chk("tmo_pulse", 32'(timeout_err), 32'h1);
    step();
    chk("tmo_keep", 32'(bus_grant), 32'h2);
    chk("tmo_clr", 32'(timeout_err), 32'h0);
`else
    chk("nolim_grant", 32'(bus_grant), 32'h1);
    chk("nolim_tmo", 32'(timeout_err), 32'h0);
    for (int c = 0; c < 20; c++) step();
    chk("nolim_long", 32'(bus_grant), 32'h1);
    chk("nolim_tmo2", 32'(timeout_err), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
